main_mem_ctrl: RTL and testbench

Parametrised main-memory model and controller behind the cache. It serves a byte-wide CPU port for uncached reads and writes, and a cache-line port that moves whole multi-word lines. Line moves are fetch (memory to cache) and write-back (cache to memory), done as one-word-per-cycle bursts. Every access waits a programmable latency, runs through a single arbitrated state machine, and ends with a one-cycle `cmplt` pulse.

---
 rtl/main_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_main_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// Main-memory model and controller: byte-wide CPU port plus cache-line burst port, one shared FSM.
// Latency: request sampled in IDLE, cmplt pulses LATENCY+N+1 cycles later (N = LINE_WORDS for line moves, 1 for bytes).
// Backpressure: requests are level-held by the requester until cmplt; losers of arbitration simply stay pending.
module main_mem_ctrl #(
    parameter int    ADDR_W     = 24,
    parameter int    WORD_W     = 32,
    parameter int    LINE_WORDS = 4,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = "mem.txt",
    localparam int   IB         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic              fetch,
    input  logic              wrt_bck,
    input  logic [ADDR_W-1:0] addr_cach,
    input  logic [WORD_W-1:0] data_cach_in,
    output logic [WORD_W-1:0] data_cach_out,
    output logic              beat_valid,
    output logic [IB-1:0]     beat_idx,
    output logic              busy,
    output logic              cmplt
);
    localparam int LANES = WORD_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int LNW   = (LB > 0) ? LB : 1;
    localparam int WA_W  = ADDR_W - LB;
    localparam int DEPTH = 2 ** WA_W;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [WA_W-1:0]   LINE_MASK = WA_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);
    localparam logic [IB-1:0]     LAST_BEAT = IB'(LINE_WORDS - 1);
    localparam logic [IB-1:0]     ONE_BEAT  = IB'(1);
    localparam logic [CNT_W-1:0]  LAT_INIT  = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // op[1] set means a whole-line move
    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_FE = 2'd2;
    localparam logic [1:0] OP_WB = 2'd3;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IB-1:0]     beat_q, beat_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [LNW-1:0]    lane_q, lane_d;
    logic [7:0]        wbyte_q, wbyte_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [WA_W-1:0]   cur_waddr;

    // Line base is aligned, so OR-ing the beat index never carries into the next line.
    assign cur_waddr = waddr_q | WA_W'(beat_q);

    // Arbitration, latency countdown, beat sequencing and output-register next values.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        wbyte_d = wbyte_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (wrt_bck | fetch | write | read) begin
                    // Write-back wins so an eviction lands before its refill.
                    if (wrt_bck)    op_d = OP_WB;
                    else if (fetch) op_d = OP_FE;
                    else if (write) op_d = OP_WR;
                    else            op_d = OP_RD;
                    if (op_d[1]) waddr_d = WA_W'(addr_cach >> LB) & ~LINE_MASK;
                    else         waddr_d = WA_W'(addr >> LB);
                    lane_d  = LNW'(addr & LANE_MASK);
                    wbyte_d = wdata;
                    beat_d  = '0;
                    cnt_d   = LAT_INIT;
                    state_d = (LATENCY > 0) ? S_WAIT : S_XFER;
                end
            end
            S_WAIT: begin
                if (cnt_q == ONE_CNT) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end
            S_XFER: begin
                if (op_q[1]) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + ONE_BEAT;
                    end
                end else begin
                    if (op_q == OP_RD) rdata_d = mem[cur_waddr][{lane_q, 3'b000} +: 8];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Fetch data is read one edge ahead so it is registered and valid throughout its beat.
        if (state_d == S_XFER && op_d == OP_FE) dout_d = mem[waddr_d | WA_W'(beat_d)];
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            beat_q  <= '0;
            waddr_q <= '0;
            lane_q  <= '0;
            wbyte_q <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            wbyte_q <= wbyte_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
        end
    end

    // Storage writes commit at the end of the transfer cycle; a reset before that edge drops them.
    always_ff @(posedge clk) begin
        if (state_q == S_XFER) begin
            if (op_q == OP_WB)      mem[cur_waddr] <= data_cach_in;
            else if (op_q == OP_WR) mem[cur_waddr][{lane_q, 3'b000} +: 8] <= wbyte_q;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign cmplt         = (state_q == S_DONE);
    assign beat_valid    = (state_q == S_XFER) && op_q[1];
    assign beat_idx      = beat_q;
    assign rdata         = rdata_q;
    assign data_cach_out = dout_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: default-shaped instance (small address space) and a LATENCY=0 / LINE_WORDS=1 instance.
// Memory contents are tracked in a word array model; byte ops and bursts are predicted from it.
module tb_main_mem_ctrl;
    localparam int LAT = 2;
    localparam int LW  = 4;
    localparam int RD = 0, WR = 1, FE = 2, WB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A signals
    logic        a_read = 1'b0, a_write = 1'b0, a_fetch = 1'b0, a_wrt_bck = 1'b0;
    logic [11:0] a_addr = '0, a_addr_cach = '0;
    logic [7:0]  a_wdata = '0;
    logic [7:0]  a_rdata;
    logic [31:0] a_dci, a_dco;
    logic        a_beat_valid, a_busy, a_cmplt;
    logic [1:0]  a_beat_idx;
    logic [31:0] wb_buf [4];
    assign a_dci = wb_buf[a_beat_idx];

    // instance B signals
    logic        b_read = 1'b0, b_write = 1'b0, b_fetch = 1'b0, b_wrt_bck = 1'b0;
    logic [7:0]  b_addr = '0, b_addr_cach = '0;
    logic [7:0]  b_wdata = '0;
    logic [7:0]  b_rdata;
    logic [31:0] b_dci = 32'hDEADBEEF;
    logic [31:0] b_dco;
    logic        b_beat_valid, b_busy, b_cmplt;
    logic [0:0]  b_beat_idx;

    main_mem_ctrl #(.ADDR_W(12), .WORD_W(32), .LINE_WORDS(LW), .LATENCY(LAT), .INIT_FILE("")) dut_a (
        .clk(clk), .rst_n(rst_n), .read(a_read), .write(a_write), .addr(a_addr),
        .wdata(a_wdata), .rdata(a_rdata), .fetch(a_fetch), .wrt_bck(a_wrt_bck),
        .addr_cach(a_addr_cach), .data_cach_in(a_dci), .data_cach_out(a_dco),
        .beat_valid(a_beat_valid), .beat_idx(a_beat_idx), .busy(a_busy), .cmplt(a_cmplt)
    );

    main_mem_ctrl #(.ADDR_W(8), .WORD_W(32), .LINE_WORDS(1), .LATENCY(0), .INIT_FILE("")) dut_b (
        .clk(clk), .rst_n(rst_n), .read(b_read), .write(b_write), .addr(b_addr),
        .wdata(b_wdata), .rdata(b_rdata), .fetch(b_fetch), .wrt_bck(b_wrt_bck),
        .addr_cach(b_addr_cach), .data_cach_in(b_dci), .data_cach_out(b_dco),
        .beat_valid(b_beat_valid), .beat_idx(b_beat_idx), .busy(b_busy), .cmplt(b_cmplt)
    );

    logic [31:0] mdl [1024];

    typedef struct {
        int          op;
        logic [11:0] a;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] ln);
        return 8'(w >> (8 * ln));
    endfunction

    // Watches instance A from the cycle after the request is driven until cmplt.
    // off = idle cycles expected before the sample edge.
    task automatic a_run(input int op, input int off, input logic [9:0] base);
        int n, nb, bsy, nexp;
        bit done;
        n = 0; nb = 0; bsy = 0; done = 0;
        nexp = (op >= FE) ? LW : 1;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (a_busy) bsy++;
            if (a_beat_valid) begin
                check("beat_idx", a_beat_idx, nb);
                check("beat_cycle", n, off + LAT + 1 + nb);
                if (op == FE) check("fetch_data", a_dco, mdl[base + 10'(nb)]);
                nb++;
            end
            if (a_cmplt) done = 1;
        end
        check("cmplt_cycle", n, off + LAT + nexp + 1);
        check("beat_count", nb, (op >= FE) ? LW : 0);
        check("busy_cycles", bsy, LAT + nexp + 1);
    endtask

    task automatic a_op(input int op, input logic [11:0] a, input logic [7:0] wd);
        logic [9:0] w, base;
        logic [1:0] ln;
        w = a[11:2]; base = {a[11:4], 2'b00}; ln = a[1:0];
        a_wdata = wd;
        if (op >= FE) begin a_addr_cach = a; a_addr = 12'($urandom); end
        else          begin a_addr = a; a_addr_cach = 12'($urandom); end
        case (op)
            RD:      a_read = 1'b1;
            WR:      a_write = 1'b1;
            FE:      a_fetch = 1'b1;
            default: a_wrt_bck = 1'b1;
        endcase
        a_run(op, 0, base);
        a_read = 1'b0; a_write = 1'b0; a_fetch = 1'b0; a_wrt_bck = 1'b0;
        case (op)
            RD: check("rdata", a_rdata, byte_of(mdl[w], ln));
            WR: mdl[w] = (mdl[w] & ~(32'hFF << (8 * ln))) | ({24'b0, wd} << (8 * ln));
            WB: for (int j = 0; j < LW; j++) mdl[base + 10'(j)] = wb_buf[j];
            default: ;
        endcase
        @(posedge clk); #1;
        check("idle_after_cmplt", {a_busy, a_cmplt, a_beat_valid}, 0);
    endtask

    task automatic b_op(input int op, input logic [7:0] a, input logic [7:0] wd, input logic [31:0] exp_dat);
        int n, nb, bsy;
        bit done;
        b_addr = a; b_addr_cach = a; b_wdata = wd;
        case (op)
            RD:      b_read = 1'b1;
            WR:      b_write = 1'b1;
            FE:      b_fetch = 1'b1;
            default: b_wrt_bck = 1'b1;
        endcase
        n = 0; nb = 0; bsy = 0; done = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (b_busy) bsy++;
            if (b_beat_valid) begin
                check("b_beat_idx", b_beat_idx, 0);
                check("b_beat_cycle", n, 1);
                if (op == FE) check("b_fetch_data", b_dco, exp_dat);
                nb++;
            end
            if (b_cmplt) done = 1;
        end
        b_read = 1'b0; b_write = 1'b0; b_fetch = 1'b0; b_wrt_bck = 1'b0;
        check("b_cmplt_cycle", n, 2);
        check("b_beat_count", nb, (op >= FE) ? 1 : 0);
        check("b_busy_cycles", bsy, 2);
        if (op == RD) check("b_rdata", b_rdata, exp_dat);
        @(posedge clk); #1;
        check("b_idle_after", {b_busy, b_cmplt}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_fe;
        logic [7:0]  last_rd;
        int n;

        vecs[0] = '{RD, 12'h002, 8'h00, 8'h33};
        vecs[1] = '{WR, 12'h005, 8'hAB, 8'h00};
        vecs[2] = '{RD, 12'h005, 8'h00, 8'hAB};
        vecs[3] = '{RD, 12'h004, 8'h00, 8'h55};
        vecs[4] = '{RD, 12'h006, 8'h00, 8'h77};
        vecs[5] = '{RD, 12'h007, 8'h00, 8'h88};
        vecs[6] = '{FE, 12'h013, 8'h00, 8'h00};
        vecs[7] = '{FE, 12'hFFF, 8'h00, 8'h00};
        vecs[8] = '{RD, 12'h00B, 8'h00, 8'hCC};
        for (int j = 0; j < LW; j++) wb_buf[j] = '0;

        // reset state of both instances
        #3;
        check("reset_a_outputs", {a_busy, a_cmplt, a_beat_valid, a_beat_idx, a_rdata, a_dco}, 0);
        check("reset_b_outputs", {b_busy, b_cmplt, b_beat_valid, b_beat_idx, b_rdata, b_dco}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fill every line through the write-back port; line 0 gets known words
        for (int l = 0; l < 256; l++) begin
            if (l == 0) begin
                wb_buf[0] = 32'h44332211; wb_buf[1] = 32'h88776655;
                wb_buf[2] = 32'hCCBBAA99; wb_buf[3] = 32'h00FFEEDD;
            end else begin
                for (int j = 0; j < LW; j++) wb_buf[j] = $urandom;
            end
            a_op(WB, 12'(l * 16), 8'h00);
        end

        // directed vectors
        for (int i = 0; i < 9; i++) begin
            a_op(vecs[i].op, vecs[i].a, vecs[i].wd);
            if (vecs[i].op == RD) check("tbl_rdata", a_rdata, vecs[i].exp_rd);
        end

        // write-back and fetch together on line 3: eviction first, then refill returns new data
        wb_buf[0] = 32'hA0; wb_buf[1] = 32'hA1; wb_buf[2] = 32'hA2; wb_buf[3] = 32'hA3;
        a_addr_cach = 12'h031;
        a_fetch = 1'b1; a_wrt_bck = 1'b1;
        a_run(WB, 0, 10'd12);
        a_wrt_bck = 1'b0;
        for (int j = 0; j < LW; j++) mdl[12 + j] = wb_buf[j];
        a_run(FE, 1, 10'd12);
        a_fetch = 1'b0;
        check("refill_last_word", a_dco, 32'hA3);
        @(posedge clk); #1;
        check("idle_after_refill", {a_busy, a_cmplt}, 0);

        // reset during beat 2 of a write-back to line 2
        for (int j = 0; j < LW; j++) wb_buf[j] = ~mdl[8 + j];
        a_addr_cach = 12'h020;
        a_wrt_bck = 1'b1;
        n = 0;
        while (!(a_beat_valid && a_beat_idx == 2'd2) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_beat2", n, LAT + 3);
        rst_n = 1'b0;
        a_wrt_bck = 1'b0;
        #2;
        check("midop_reset_outputs", {a_busy, a_cmplt, a_beat_valid, a_beat_idx, a_rdata, a_dco}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl[8] = wb_buf[0];
        mdl[9] = wb_buf[1];
        a_op(FE, 12'h020, 8'h00);

        // randomized traffic against the model
        last_rd = 8'h00;
        last_fe = mdl[11];
        for (int i = 0; i < 60; i++) begin
            int op;
            logic [11:0] a;
            logic [7:0] wd;
            op = $urandom_range(0, 3);
            a  = 12'($urandom);
            wd = 8'($urandom);
            if (op == WB) for (int j = 0; j < LW; j++) wb_buf[j] = $urandom;
            if (op == FE) last_fe = mdl[{a[11:4], 2'b11}];
            if (op == RD) last_rd = byte_of(mdl[a[11:2]], a[1:0]);
            a_op(op, a, wd);
            check("rdata_hold", a_rdata, last_rd);
            check("dout_hold", a_dco, last_fe);
        end

        // zero-latency, single-word-line instance
        b_op(WB, 8'h10, 8'h00, 32'h0);
        b_op(FE, 8'h13, 8'h00, 32'hDEADBEEF);
        b_op(RD, 8'h11, 8'h00, 32'h000000BE);
        b_op(WR, 8'h12, 8'h5A, 32'h0);
        b_op(FE, 8'h10, 8'h00, 32'hDE5ABEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
